// File: rtl/gs_row_feeder.sv
// Row sequencer for a Gauss-Seidel core: holds the coefficient rows and the
// solution vector, issues one row per request, and streams the result back out.
module gs_row_feeder #(
  parameter int N_ROW = 8,
  parameter int TMO   = 1024
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load_valid,
  input  logic [2:0]   i_load_row,
  input  logic [55:0]  i_load_a,
  input  logic [7:0]   i_load_b,
  input  logic [31:0]  i_load_adown,
  input  logic         i_start,
  input  logic [7:0]   i_iter,
  output logic         o_core_reset,
  output logic         o_core_valid,
  output logic [55:0]  o_a,
  output logic [7:0]   o_b,
  output logic [31:0]  o_a_down,
  output logic [223:0] o_x,
  input  logic         i_core_valid,
  input  logic [31:0]  i_x_next,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_err,
  output logic         o_x_valid,
  output logic [2:0]   o_x_idx,
  output logic [31:0]  o_x_data
);

  // state | meaning
  // IDLE  | accepts row loads and start
  // CLR   | one-cycle clear pulse to the core
  // ISSUE | one-cycle request pulse, operands presented
  // WAIT  | waiting for core result, timeout down-counter running
  // OUT   | streaming x[0..7], then one-cycle done
  typedef enum logic [2:0] {IDLE, CLR, ISSUE, WAIT, OUT} state_t;

  localparam int TW = $clog2(TMO + 1);

  state_t        state;
  logic [55:0]   st_a  [N_ROW];
  logic [7:0]    st_b  [N_ROW];
  logic [31:0]   st_ad [N_ROW];
  logic [31:0]   x     [N_ROW];
  logic [2:0]    row;
  logic [7:0]    sweep;
  logic [7:0]    iter;
  logic [TW-1:0] tmo_cnt;

  assign o_a      = st_a[row];
  assign o_b      = st_b[row];
  assign o_a_down = st_ad[row];
  assign o_x_data = o_x_valid ? x[o_x_idx] : '0;

  // Field k carries the k-th x index that skips the current row.
  always_comb begin
    logic [2:0] j;
    j   = '0;
    o_x = '0;
    for (int k = 0; k < 7; k++) begin
      j = (3'(k) < row) ? 3'(k) : 3'(k + 1);
      o_x[32*k +: 32] = x[j];
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      row          <= '0;
      sweep        <= '0;
      iter         <= '0;
      tmo_cnt      <= '0;
      o_core_reset <= 1'b0;
      o_core_valid <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_err        <= 1'b0;
      o_x_valid    <= 1'b0;
      o_x_idx      <= '0;
      for (int i = 0; i < N_ROW; i++) begin
        st_a[i]  <= '0;
        st_b[i]  <= '0;
        st_ad[i] <= '0;
        x[i]     <= '0;
      end
    end else begin
      o_core_reset <= 1'b0;
      o_core_valid <= 1'b0;
      o_done       <= 1'b0;
      case (state)
        IDLE: begin
          if (i_load_valid) begin
            st_a[i_load_row]  <= i_load_a;
            st_b[i_load_row]  <= i_load_b;
            st_ad[i_load_row] <= i_load_adown;
          end
          if (i_start) begin
            for (int i = 0; i < N_ROW; i++) x[i] <= '0;
            iter   <= i_iter;
            row    <= '0;
            sweep  <= '0;
            o_err  <= 1'b0;
            o_busy <= 1'b1;
            if (i_iter != 8'd0) begin
              state        <= CLR;
              o_core_reset <= 1'b1;
            end else begin
              state     <= OUT;
              o_x_valid <= 1'b1;
              o_x_idx   <= '0;
            end
          end
        end
        CLR: begin
          state        <= ISSUE;
          o_core_valid <= 1'b1;
        end
        ISSUE: begin
          state   <= WAIT;
          tmo_cnt <= TW'(TMO - 1);
        end
        WAIT: begin
          // A result arriving on the terminal-count cycle takes priority.
          if (i_core_valid) begin
            x[row] <= i_x_next;
            if (row == 3'd7) begin
              row   <= '0;
              sweep <= sweep + 8'd1;
              if (sweep + 8'd1 == iter) begin
                state     <= OUT;
                o_x_valid <= 1'b1;
                o_x_idx   <= '0;
              end else begin
                state        <= CLR;
                o_core_reset <= 1'b1;
              end
            end else begin
              row          <= row + 3'd1;
              state        <= CLR;
              o_core_reset <= 1'b1;
            end
          end else if (tmo_cnt == TW'(1)) begin
            o_err  <= 1'b1;
            o_busy <= 1'b0;
            state  <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt - TW'(1);
          end
        end
        OUT: begin
          if (o_x_idx == 3'd7) begin
            o_x_valid <= 1'b0;
            o_x_idx   <= '0;
            o_done    <= 1'b1;
            o_busy    <= 1'b0;
            state     <= IDLE;
          end else begin
            o_x_idx <= o_x_idx + 3'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gs_row_feeder.sv
// Scoreboard bench for gs_row_feeder: random rows and sweeps against a plain
// Gauss-Seidel reference, with a behavioural core answering requests.
module tb_gs_row_feeder;
  localparam int TMO = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         load_valid;
  logic [2:0]   load_row;
  logic [55:0]  load_a;
  logic [7:0]   load_b;
  logic [31:0]  load_adown;
  logic         start;
  logic [7:0]   iter_in;
  logic         core_reset, core_req;
  logic [55:0]  a_out;
  logic [7:0]   b_out;
  logic [31:0]  adown_out;
  logic [223:0] x_out;
  logic         core_valid;
  logic [31:0]  x_next;
  logic         busy, done, err, x_valid;
  logic [2:0]   x_idx;
  logic [31:0]  x_data;

  logic         cv_resp, cv_stray;
  logic [31:0]  xn_resp;
  assign core_valid = cv_resp | cv_stray;
  assign x_next     = cv_stray ? 32'hDEAD_BEEF : xn_resp;

  always #5 clk = ~clk;

  gs_row_feeder #(.N_ROW(8), .TMO(TMO)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_load_valid(load_valid), .i_load_row(load_row), .i_load_a(load_a),
    .i_load_b(load_b), .i_load_adown(load_adown),
    .i_start(start), .i_iter(iter_in),
    .o_core_reset(core_reset), .o_core_valid(core_req),
    .o_a(a_out), .o_b(b_out), .o_a_down(adown_out), .o_x(x_out),
    .i_core_valid(core_valid), .i_x_next(x_next),
    .o_busy(busy), .o_done(done), .o_err(err),
    .o_x_valid(x_valid), .o_x_idx(x_idx), .o_x_data(x_data)
  );

  int tot = 0;
  int bad = 0;

  function automatic void check(string name, logic [255:0] act, logic [255:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endfunction

  // bench copy of the row store
  logic [55:0] m_a  [8];
  logic [7:0]  m_b  [8];
  logic [31:0] m_ad [8];

  typedef struct { logic [2:0] idx; logic [31:0] data; } item_t;
  item_t expq[$];

  // core behaviour knobs, written only by the main sequence
  int          mode;     // 0: answer 100+row, 1: sum of others + row + salt
  logic [31:0] salt;
  int          dly;
  bit          resp_en;
  int          op_gen;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Reference: straightforward Gauss-Seidel sweeps over an 8-entry vector.
  function automatic void model_op(int n_iter);
    logic [31:0] mx [8];
    logic [31:0] s;
    item_t it;
    for (int i = 0; i < 8; i++) mx[i] = '0;
    for (int sw = 0; sw < n_iter; sw++)
      for (int r = 0; r < 8; r++) begin
        s = '0;
        for (int j = 0; j < 8; j++) if (j != r) s = s + mx[j];
        mx[r] = (mode == 0) ? 32'(100 + r) : s + 32'(r) + salt;
      end
    for (int i = 0; i < 8; i++) begin
      it.idx  = 3'(i);
      it.data = mx[i];
      expq.push_back(it);
    end
  endfunction

  // Core responder: checks operands at each request and answers after dly cycles.
  int           r_gen = 0;
  int           r_cnt = 0;
  int           rrow;
  int           issue_cyc = 0;
  logic [31:0]  r_x [8];
  logic [223:0] eo;
  logic [223:0] seen_ox [8];
  logic [31:0]  rsum, rval;
  initial begin
    cv_resp = 1'b0;
    xn_resp = '0;
    for (int i = 0; i < 8; i++) begin r_x[i] = '0; seen_ox[i] = '0; end
    forever begin
      @(negedge clk);
      if (r_gen != op_gen) begin
        r_gen = op_gen;
        r_cnt = 0;
        for (int i = 0; i < 8; i++) r_x[i] = '0;
      end
      if (rst_n && core_req) begin
        rrow = r_cnt % 8;
        r_cnt++;
        issue_cyc = cyc;
        check("issue_a", 256'(a_out), 256'(m_a[rrow]));
        check("issue_b", 256'(b_out), 256'(m_b[rrow]));
        check("issue_adown", 256'(adown_out), 256'(m_ad[rrow]));
        eo   = '0;
        rsum = '0;
        for (int k = 0; k < 7; k++) begin
          eo[32*k +: 32] = r_x[(k < rrow) ? k : k + 1];
          rsum = rsum + r_x[(k < rrow) ? k : k + 1];
        end
        check("issue_x", 256'(x_out), 256'(eo));
        seen_ox[rrow] = x_out;
        rval = (mode == 0) ? 32'(100 + rrow) : rsum + 32'(rrow) + salt;
        r_x[rrow] = rval;
        if (resp_en) begin
          repeat (dly) @(posedge clk);
          #1;
          cv_resp = 1'b1;
          xn_resp = rval;
          @(posedge clk);
          #1;
          cv_resp = 1'b0;
        end
      end
    end
  end

  // Output monitor: pops the scoreboard on every streamed value.
  int    done_cnt = 0;
  int    n_rst = 0;
  int    n_val = 0;
  item_t got;
  always @(negedge clk) begin
    if (rst_n) begin
      if (core_reset) n_rst++;
      if (core_req) n_val++;
      if (x_valid) begin
        if (expq.size() == 0) begin
          check("stream_unexpected", 256'(x_idx), 256'(4'd8));
        end else begin
          got = expq.pop_front();
          check("stream_idx", 256'(x_idx), 256'(got.idx));
          check("stream_data", 256'(x_data), 256'(got.data));
        end
      end
      if (done) begin
        done_cnt++;
        check("done_after_stream", 256'(expq.size()), 256'(0));
      end
    end
  end

  task automatic load(int r, bit upd);
    load_valid = 1'b1;
    load_row   = 3'(r);
    load_a     = 56'({$urandom(), $urandom()});
    load_b     = 8'($urandom());
    load_adown = $urandom();
    if (upd) begin
      m_a[r]  = load_a;
      m_b[r]  = load_b;
      m_ad[r] = load_adown;
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
  endtask

  task automatic load_all();
    for (int r = 0; r < 8; r++) load(r, 1'b1);
  endtask

  task automatic start_op(int n);
    op_gen++;
    iter_in = 8'(n);
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(int budget, string name);
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != d0) break;
    end
    #1;
    check(name, 256'(done_cnt - d0), 256'(1));
  endtask

  task automatic check_idle_outputs(string tag);
    check({tag, "_busy"}, 256'(busy), 256'(0));
    check({tag, "_done"}, 256'(done), 256'(0));
    check({tag, "_err"}, 256'(err), 256'(0));
    check({tag, "_core_rst"}, 256'(core_reset), 256'(0));
    check({tag, "_core_req"}, 256'(core_req), 256'(0));
    check({tag, "_xvalid"}, 256'(x_valid), 256'(0));
    check({tag, "_xidx"}, 256'(x_idx), 256'(0));
    check({tag, "_xdata"}, 256'(x_data), 256'(0));
    check({tag, "_ops"}, 256'({a_out, b_out, adown_out}), 256'(0));
    check({tag, "_ox"}, 256'(x_out), 256'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int v0, r0, d0;
    logic [223:0] ox3;
    rst_n = 1'b0; load_valid = 1'b0; load_row = '0; load_a = '0; load_b = '0;
    load_adown = '0; start = 1'b0; iter_in = '0; cv_stray = 1'b0;
    mode = 0; salt = '0; dly = 3; resp_en = 1'b1; op_gen = 0;
    for (int i = 0; i < 8; i++) begin m_a[i] = '0; m_b[i] = '0; m_ad[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // one sweep, core answers 100+row after 3 cycles
    load_all();
    mode = 0; salt = '0; dly = 3;
    model_op(1);
    v0 = n_val;
    start_op(1);
    check("busy_after_start", 256'(busy), 256'(1));
    wait_done(400, "sweep1_done");
    ox3 = {32'd0, 32'd0, 32'd0, 32'd0, 32'd102, 32'd101, 32'd100};
    check("row3_ox", 256'(seen_ox[3]), 256'(ox3));
    check("sweep1_reqs", 256'(n_val - v0), 256'(8));
    check("idle_busy", 256'(busy), 256'(0));

    // zero sweeps: stream zeros, no requests
    v0 = n_val;
    model_op(0);
    start_op(0);
    wait_done(40, "iter0_done");
    check("iter0_reqs", 256'(n_val - v0), 256'(0));

    // three sweeps with data-dependent answers
    mode = 1; salt = '0; dly = 2;
    r0 = n_rst; v0 = n_val;
    model_op(3);
    start_op(3);
    wait_done(1000, "sweep3_done");
    check("sweep3_clr_pulses", 256'(n_rst - r0), 256'(24));
    check("sweep3_req_pulses", 256'(n_val - v0), 256'(24));

    // random rows, sweeps, latencies and answers
    for (int t = 0; t < 4; t++) begin
      int n;
      for (int k = 0; k < 3; k++) load(int'($urandom_range(0, 7)), 1'b1);
      n    = int'($urandom_range(1, 3));
      mode = 1;
      salt = $urandom();
      dly  = int'($urandom_range(1, 5));
      model_op(n);
      start_op(n);
      wait_done(1500, "rand_done");
    end

    // timeout with a silent core
    resp_en = 1'b0;
    d0 = done_cnt;
    start_op(1);
    for (int i = 0; i < TMO + 20; i++) begin
      @(negedge clk);
      if (err) break;
    end
    check("tmo_latency", 256'(cyc - issue_cyc), 256'(TMO));
    check("tmo_busy", 256'(busy), 256'(0));
    repeat (3) @(posedge clk);
    #1;
    check("tmo_err_held", 256'(err), 256'(1));
    check("tmo_no_done", 256'(done_cnt - d0), 256'(0));

    // answer on the terminal cycle is accepted
    resp_en = 1'b1;
    mode = 0; dly = TMO - 1;
    model_op(1);
    start_op(1);
    check("err_cleared_on_start", 256'(err), 256'(0));
    wait_done(600, "tmo_edge_done");
    check("tmo_edge_err", 256'(err), 256'(0));

    // start/load during WAIT and stray core_valid during OUT are ignored
    mode = 1; salt = $urandom(); dly = 8;
    model_op(1);
    start_op(1);
    repeat (3) @(posedge clk);
    #1;
    iter_in = 8'd5;
    start   = 1'b1;
    load(2, 1'b0);
    start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (x_valid) break;
    end
    @(posedge clk);
    #1;
    cv_stray = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    cv_stray = 1'b0;
    wait_done(40, "robust_done");
    dly = 1;
    model_op(1);
    start_op(1);
    wait_done(300, "robust_store_done");

    // asynchronous reset mid-operation
    dly = 4;
    start_op(2);
    repeat (5) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("async_rst");
    expq.delete();
    for (int i = 0; i < 8; i++) begin m_a[i] = '0; m_b[i] = '0; m_ad[i] = '0; end
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("rst_no_done", 256'(done_cnt - d0), 256'(0));
    check("rst_stays_idle", 256'(busy), 256'(0));

    // fresh operation after reset
    load_all();
    mode = 1; salt = $urandom(); dly = 2;
    model_op(2);
    start_op(2);
    wait_done(800, "post_rst_done");

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule

// File: doc/gs_row_feeder.md
GS_ROW_FEEDER -- requirements
Module: gs_row_feeder

Interface
REQ-001 SHALL have parameter N_ROW, default 8, number of unknowns (fixed at 8 for this release).
REQ-002 SHALL have parameter TMO, default 1024, max cycles waiting for a core response.
REQ-003 SHALL have port i_clk  in  1  single clock, all flops on rising edge.
REQ-004 SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port i_load_valid  in  1  host writes one coefficient row this cycle.
REQ-006 SHALL have port i_load_row  in  3  row index for the load.
REQ-007 SHALL have port i_load_a  in  56  seven 8-bit off-diagonal coefficients, stored verbatim.
REQ-008 SHALL have port i_load_b  in  8  right-hand-side term.
REQ-009 SHALL have port i_load_adown  in  32  diagonal-reciprocal term.
REQ-010 SHALL have port i_start  in  1  start pulse.
REQ-011 SHALL have port i_iter  in  8  number of sweeps, sampled on accepted i_start.
REQ-012 SHALL have port o_core_reset  out  1  active-high clear pulse to core.
REQ-013 SHALL have port o_core_valid  out  1  request pulse to core.
REQ-014 SHALL have ports o_a (56), o_b (8), o_a_down (32), o_x (224)  out  operands to core.
REQ-015 SHALL have ports i_core_valid  in  1 and i_x_next  in  32  core result.
REQ-016 SHALL have ports o_busy (1), o_done (1), o_err (1)  out  status.
REQ-017 SHALL have ports o_x_valid (1), o_x_idx (3), o_x_data (32)  out  serial solution stream.

Function
REQ-018 SHALL implement states IDLE, CLR, ISSUE, WAIT, OUT.
REQ-019 SHALL accept loads only in IDLE, writing row store[i_load_row]; loads elsewhere ignored.
REQ-020 SHALL, on i_start in IDLE: clear x[0..7] to 0, latch i_iter, row=0, sweep=0, clear o_err; go CLR if i_iter!=0, else OUT.
REQ-021 SHALL ignore i_start outside IDLE.
REQ-022 CLR: o_core_reset=1 for exactly one cycle, then ISSUE.
REQ-023 ISSUE: o_core_valid=1 for exactly one cycle, then WAIT, timeout counter cleared.
REQ-024 SHALL drive o_a/o_b/o_a_down from store[row] and o_x from x registers, stable from ISSUE through WAIT.
REQ-025 o_x field k (bits 32k+31:32k, k=0..6) SHALL be x[j], j the k-th index ≠ row ascending.
REQ-026 WAIT, i_core_valid=1: x[row] <= i_x_next; row==7 -> row=0, sweep+1, go OUT if sweep+1==latched iter else CLR; row<7 -> row+1, CLR.
REQ-027 Updated x[row] SHALL be visible in o_x of the next row's ISSUE (Gauss-Seidel ordering).
REQ-028 i_core_valid outside WAIT SHALL be ignored.
REQ-029 WAIT SHALL count cycles; reaching TMO without i_core_valid -> o_err=1 (held until next accepted start), go IDLE, no o_done.
REQ-030 i_core_valid in the same cycle as timeout SHALL win (result accepted, no error).
REQ-031 OUT: one value per cycle, o_x_valid=1, o_x_idx=0..7, o_x_data=x[idx]; after idx 7, o_done=1 one cycle, go IDLE.
REQ-032 o_busy SHALL be 1 in every state except IDLE.
REQ-033 Per-row latency SHALL be 2 cycles + core response time; no cycle gap between WAIT and next CLR.

Reset
REQ-034 i_rst_n low SHALL immediately force IDLE; all outputs 0; x, row, sweep, counters, row store cleared to 0.
REQ-035 Reset mid-operation SHALL abort with no o_done; operation restarts only on a new i_start.

Verification
REQ-036 Reset: assert i_rst_n=0 mid-cycle -> all outputs 0 asynchronously, o_busy=0.
REQ-037 One sweep: load rows, i_iter=1, core model answers 100+row after 3 cycles -> row 3 ISSUE o_x = {0,0,0,0,102,101,100} (field 6..0), stream 100..107, o_done once.
REQ-038 i_iter=0: start -> 8 zero outputs idx 0..7, o_done, no o_core_valid ever.
REQ-039 Three sweeps: core model returns x_next = sum of o_x fields + row -> stream matches software Gauss-Seidel model; exactly 24 o_core_reset and 24 o_core_valid pulses.
REQ-040 Timeout: core silent -> o_err=1 exactly TMO cycles after ISSUE, o_busy=0, no o_done; response on cycle TMO instead -> accepted, o_err=0.
REQ-041 Busy robustness: i_start and i_load_valid during WAIT, stray i_core_valid during OUT -> no state, store, or x change.
